ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ADDR_W, default 16, instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 The block SHALL have a single clock `clk` and an asynchronous active-low reset `rst_f`.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_f  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  read request to instruction memory.
REQ-007 imem_addr  output  ADDR_W  word address of the request.
REQ-008 imem_valid  input  1  read data returned this cycle, at least 1 cycle after request.
REQ-009 imem_rdata  input  32  instruction word returned.
REQ-010 ir  output  32  instruction register presented to the processor core.
REQ-011 ir_valid  output  1  ir holds an unconsumed instruction.
REQ-012 ir_ack  input  1  core consumes ir this cycle; ignored when ir_valid=0.
REQ-013 br_taken  input  1  redirect request from control.
REQ-014 br_target  input  ADDR_W  absolute redirect target, or signed offset when the relative mode is in use.
REQ-015 pc_out  output  ADDR_W  address of the instruction in ir.

Function
REQ-016 FSM states SHALL be FETCH, WAIT, FULL.
REQ-017 FETCH: imem_req=1, imem_addr=pc; next state WAIT.
REQ-018 WAIT: imem_req=0; on imem_valid, ir<=imem_rdata, pc_out<=pc, pc<=pc+1, ir_valid<=1, next state FULL.
REQ-019 FULL: hold ir; on ir_ack, ir_valid<=0 next cycle, next state FETCH.
REQ-020 Latency from FETCH entry to ir_valid SHALL be 1 cycle plus the memory latency; back-to-back throughput SHALL be one instruction per 3 cycles with 1-cycle memory.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_W, with 2^ADDR_W-1 advancing to 0.
REQ-022 br_taken in any state SHALL set pc to the redirect target, clear ir_valid on the next edge, and force the next state to FETCH.
REQ-023 br_taken in WAIT SHALL cause the returning imem_valid for the old request to be discarded via a one-bit drop flag, with no ir update.
REQ-024 br_taken and ir_ack in the same cycle: br_taken SHALL win.
REQ-025 imem_valid outside WAIT, or while the drop flag is clear in FETCH or FULL, SHALL be ignored.

Reset
REQ-026 While rst_f=0, the block SHALL hold: state=FETCH, pc=RESET_PC, ir=0, ir_valid=0, pc_out=0, imem_req=0, and drop flag=0.
REQ-027 The first imem_req SHALL assert in the first cycle after rst_f deasserts.
REQ-028 Reset in the middle of WAIT SHALL abandon the outstanding request, and its late imem_valid SHALL be ignored.

Configuration
REQ-029 The block SHALL use the macro IFETCH_REL_BRANCH_EN.
REQ-030 When IFETCH_REL_BRANCH_EN is defined, the redirect target SHALL be pc_out+1+sign-extended br_target, wrapping modulo 2^ADDR_W.
REQ-031 When IFETCH_REL_BRANCH_EN is not defined, the redirect target SHALL be br_target, taken as absolute.

Structure
REQ-032 The shared package sisc_pkg SHALL hold the FSM state enum, RESET_PC default, and the instruction-word width constant of 32.
REQ-033 One sub-module, pc_reg, is natural: PC register with increment, load, and wrap logic.
REQ-034 The FSM and IR latch SHALL stay in ifetch.

Verification
REQ-035 Reset release with 1-cycle memory returning 0x1000_0000 at address 0 -> imem_req at cycle 1, ir=0x1000_0000, ir_valid=1 at cycle 3, pc_out=0.
REQ-036 Hold ir_ack=0 for 5 cycles -> ir stable, no imem_req; then ir_ack=1 -> next request addr=1.
REQ-037 br_taken in WAIT, absolute target 0x0040 -> stale data dropped, next imem_addr=0x0040, ir_valid stays 0 until the new data returns.
REQ-038 PC at 0xFFFF, fetch completes -> next imem_addr=0x0000.
REQ-039 With IFETCH_REL_BRANCH_EN, pc_out=0x0010, br_target=0xFFFE -> next imem_addr=0x000F.
REQ-040 Simultaneous br_taken and ir_ack in FULL -> redirect taken, no fetch from pc_out+1.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared definitions for the instruction-fetch slice: fetch FSM encoding,
// instruction word width and the default reset PC.
package sisc_pkg;

    localparam int INSTR_W          = 32;
    localparam int DEFAULT_RESET_PC = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_if.sv
// Bus bundle between the fetch unit (master) and its environment (slave):
// instruction-memory read port, instruction register hand-off and redirect input.
interface ifetch_if #(
    parameter int ADDR_W = 16
);

    // imem: imem_req is a one-cycle strobe carrying imem_addr; at most one read is
    // outstanding and imem_valid/imem_rdata return it at least one cycle later, in order.
    // ir: ir/pc_out are held while ir_valid=1 until a cycle with ir_ack=1 consumes them;
    // br_taken in the same cycle overrides ir_ack.
    logic                         imem_req;
    logic [ADDR_W-1:0]            imem_addr;
    logic                         imem_valid;
    logic [sisc_pkg::INSTR_W-1:0] imem_rdata;
    logic [sisc_pkg::INSTR_W-1:0] ir;
    logic                         ir_valid;
    logic                         ir_ack;
    logic                         br_taken;
    logic [ADDR_W-1:0]            br_target;
    logic [ADDR_W-1:0]            pc_out;

    modport master (
        output imem_req, imem_addr, ir, ir_valid, pc_out,
        input  imem_valid, imem_rdata, ir_ack, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_valid, pc_out,
        output imem_valid, imem_rdata, ir_ack, br_taken, br_target
    );

endinterface

// File: rtl/ifetch_pc_reg.sv
// Program counter register: load beats increment, increment wraps modulo 2^ADDR_W.
module pc_reg
    import sisc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: FETCH/WAIT/FULL sequencer, instruction register and redirect.
// Define IFETCH_REL_BRANCH_EN to treat br_target as an offset from pc_out+1.
module ifetch
    import sisc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst_f,
    ifetch_if.master     bus,
    output fetch_state_t state_dbg_o
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic               drop_q, drop_d;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  br_dest;
    logic               pc_inc;
    logic               pc_load;

`ifdef IFETCH_REL_BRANCH_EN
    // Operands share the PC width, so sign extension reduces to a modular add.
    assign br_dest = pc_out_q + ADDR_W'(1) + bus.br_target;
`else
    assign br_dest = bus.br_target;
`endif

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_f      (rst_f),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (br_dest),
        .pc_o       (pc)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc_out_d   = pc_out_q;
        drop_d     = drop_q;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;

        // The abandoned read's response clears the flag wherever it lands.
        if (drop_q && bus.imem_valid) begin
            drop_d = 1'b0;
        end

        case (state_q)
            FETCH: state_d = WAIT;
            WAIT: begin
                if (bus.imem_valid && !drop_q) begin
                    ir_d       = bus.imem_rdata;
                    pc_out_d   = pc;
                    pc_inc     = 1'b1;
                    ir_valid_d = 1'b1;
                    state_d    = FULL;
                end
            end
            FULL: begin
                if (bus.ir_ack) begin
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (bus.br_taken) begin
            state_d    = FETCH;
            ir_d       = ir_q;
            ir_valid_d = 1'b0;
            pc_out_d   = pc_out_q;
            pc_inc     = 1'b0;
            pc_load    = 1'b1;
            // Mark the read still in flight so its response is discarded.
            if (state_q == WAIT && !(bus.imem_valid && !drop_q)) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= FETCH;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pc_out_q   <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc_out_q   <= pc_out_d;
            drop_q     <= drop_d;
        end
    end

    // A redirect in FETCH withholds the strobe so no read is issued for the old PC.
    assign bus.imem_req  = rst_f && (state_q == FETCH) && !bus.br_taken;
    assign bus.imem_addr = pc;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.pc_out    = pc_out_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: memory responder with programmable latency,
// request and instruction scoreboards, directed scenarios for reset, hold, redirect and wrap.
module tb_ifetch;
    import sisc_pkg::*;

    localparam int ADDR_W = 16;
`ifdef IFETCH_REL_BRANCH_EN
    localparam logic [15:0] EXP_FFFE_DEST = 16'h000F;
`else
    localparam logic [15:0] EXP_FFFE_DEST = 16'hFFFE;
`endif

    logic         clk = 1'b0;
    logic         rst_f;
    fetch_state_t state_dbg;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_lat = 1;
    logic [15:0] model_pc_out = 16'h0000;
    logic        prev_valid = 1'b0;

    logic [47:0] exp_q[$];
    logic [15:0] exp_addr_q[$];
    logic [15:0] pend_addr[$];
    int          pend_cnt[$];

    ifetch_if #(.ADDR_W(ADDR_W)) bus ();

    ifetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_data(input logic [15:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    function automatic logic [15:0] br_field(input logic [15:0] want);
`ifdef IFETCH_REL_BRANCH_EN
        return want - model_pc_out - 16'd1;
`else
        return want;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.br_taken = 1'b0;
    endtask

    task automatic push_fetch(input logic [15:0] a);
        exp_addr_q.push_back(a);
        exp_q.push_back({a, mem_data(a)});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            next_cycle();
            @(negedge clk);
            n++;
        end while (!bus.ir_valid && n < 40);
        check_eq("valid_timeout", 32'(bus.ir_valid), 32'd1);
    endtask

    // ---------------- memory responder ----------------
    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.imem_valid = 1'b0;
            for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i] = pend_cnt[i] - 1;
            if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
                void'(pend_cnt.pop_front());
                bus.imem_valid = 1'b1;
                bus.imem_rdata = mem_data(pend_addr.pop_front());
            end
            if (bus.imem_req) begin
                pend_addr.push_back(bus.imem_addr);
                pend_cnt.push_back(mem_lat);
            end
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (bus.imem_req) begin
                check_eq("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0)
                    check_eq("req_addr", 32'(bus.imem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (bus.ir_valid && !prev_valid) begin
                check_eq("ir_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("ir_data", bus.ir, e[31:0]);
                    check_eq("ir_pc_out", 32'(bus.pc_out), 32'(e[47:32]));
                    model_pc_out = e[47:32];
                end
            end
            prev_valid = bus.ir_valid;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_f         = 1'b0;
        bus.ir_ack    = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_ir", bus.ir, 32'h0);
        check_eq("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("rst_pc_out", 32'(bus.pc_out), 32'd0);
        check_eq("rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(FETCH));

        // Reset release: request in cycle 1, instruction valid in cycle 3
        push_fetch(16'h0000);
        @(posedge clk);
        #1;
        rst_f = 1'b1;
        @(negedge clk);
        check_eq("c1_req", 32'(bus.imem_req), 32'd1);
        check_eq("c1_addr", 32'(bus.imem_addr), 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("c2_ir_valid", 32'(bus.ir_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("c3_ir_valid", 32'(bus.ir_valid), 32'd1);
        check_eq("c3_ir", bus.ir, 32'h1000_0000);
        check_eq("c3_pc_out", 32'(bus.pc_out), 32'd0);

        // Core stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            check_eq("hold_ir", bus.ir, 32'h1000_0000);
            check_eq("hold_no_req", 32'(bus.imem_req), 32'd0);
        end

        // Back-to-back consumption: one instruction every 3 cycles
        for (int a = 1; a <= 4; a++) push_fetch(16'(a));
        next_cycle();
        bus.ir_ack = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            check_eq("b2b_gap", 32'(n), 32'd3);
        end

        // Redirect while waiting on a slow read: stale data must be dropped
        exp_addr_q.push_back(16'h0005);
        next_cycle();
        bus.ir_ack = 1'b0;
        mem_lat    = 3;
        @(negedge clk);
        next_cycle();
        bus.br_taken  = 1'b1;
        bus.br_target = br_field(16'h0040);
        push_fetch(16'h0040);
        @(negedge clk);
        check_eq("wait_br_req", 32'(bus.imem_req), 32'd0);
        wait_valid(n);
        check_eq("drop_latency", 32'(n), 32'd5);

        // Redirect and ack together in FULL: redirect wins
        mem_lat = 1;
        push_fetch(16'h0100);
        next_cycle();
        bus.ir_ack    = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = br_field(16'h0100);
        @(negedge clk);
        next_cycle();
        bus.ir_ack = 1'b0;
        @(negedge clk);
        check_eq("br_ack_cleared", 32'(bus.ir_valid), 32'd0);
        check_eq("br_ack_req", 32'(bus.imem_req), 32'd1);
        wait_valid(n);
        check_eq("br_ack_latency", 32'(n), 32'd2);

        // PC wrap from 0xFFFF to 0x0000
        push_fetch(16'hFFFF);
        next_cycle();
        bus.br_taken  = 1'b1;
        bus.br_target = br_field(16'hFFFF);
        @(negedge clk);
        wait_valid(n);
        check_eq("top_fetch_latency", 32'(n), 32'd3);
        push_fetch(16'h0000);
        next_cycle();
        bus.ir_ack = 1'b1;
        @(negedge clk);
        next_cycle();
        bus.ir_ack = 1'b0;
        @(negedge clk);
        check_eq("wrap_addr", 32'(bus.imem_addr), 32'd0);
        wait_valid(n);
        check_eq("wrap_latency", 32'(n), 32'd2);

        // pc_out=0x0010 then br_target=0xFFFE (offset -2 in relative mode)
        push_fetch(16'h0010);
        next_cycle();
        bus.br_taken  = 1'b1;
        bus.br_target = br_field(16'h0010);
        @(negedge clk);
        wait_valid(n);
        check_eq("to_0010_latency", 32'(n), 32'd3);
        push_fetch(EXP_FFFE_DEST);
        next_cycle();
        bus.br_taken  = 1'b1;
        bus.br_target = 16'hFFFE;
        @(negedge clk);
        wait_valid(n);
        check_eq("fffe_latency", 32'(n), 32'd3);

        // Reset during WAIT: the abandoned read returns after release and is ignored
        mem_lat = 3;
        exp_addr_q.push_back(EXP_FFFE_DEST + 16'd1);
        next_cycle();
        bus.ir_ack = 1'b1;
        @(negedge clk);
        next_cycle();
        bus.ir_ack = 1'b0;
        @(negedge clk);
        next_cycle();
        rst_f = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ir", bus.ir, 32'h0);
        check_eq("mid_rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("mid_rst_pc_out", 32'(bus.pc_out), 32'd0);
        check_eq("mid_rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("mid_rst_state", 32'(state_dbg), 32'(FETCH));
        next_cycle();
        push_fetch(16'h0000);
        next_cycle();
        rst_f = 1'b1;
        @(negedge clk);
        wait_valid(n);
        check_eq("post_rst_latency", 32'(n), 32'd4);

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check_eq("exp_addr_q_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
